// File: rtl/preg_free_list_pkg.sv
// Shared core sizing constants for the physical register file, rename and issue queue.
// Also holds the register type and pointer helper used by the free list.
package preg_free_list_pkg;

    localparam int NUM_PREG = 64;
    localparam int NUM_AREG = 32;
    localparam int PREG_W   = 6;
    localparam int FL_DEPTH = 32;
    localparam int PTR_W    = 5;
    localparam int CNT_W    = 6;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;
    typedef logic [CNT_W-1:0]  fl_cnt_t;

    // Pointers are exactly log2(FL_DEPTH) wide, so the natural overflow is the 31 -> 0 wrap.
    function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
        return p + fl_ptr_t'(1);
    endfunction

endpackage

// File: rtl/preg_free_list_if.sv
// Rename/commit/writeback port bundle of the physical register free list.
// master = rename/commit/writeback side, slave = the free list.
interface preg_free_list_if;
    import preg_free_list_pkg::*;

    // ALLOC_REQ is a request; ALLOC_GNT (same cycle) means the request was taken and
    // ALLOC_PREG is consumed at the edge. FREE_VALID / WB_VALID are fire-and-forget
    // strobes with no backpressure: a free that cannot be taken is dropped.
    logic                ALLOC_REQ;
    preg_t               ALLOC_PREG;
    logic                ALLOC_GNT;
    logic                STALL;
    fl_cnt_t             FREE_COUNT;
    logic                FREE_VALID;
    preg_t               FREE_PREG;
    logic                WB_VALID;
    preg_t               WB_PREG;
    logic [NUM_PREG-1:0] READY_BITS;
    logic                ERR_DOUBLE_FREE;

    modport master (
        output ALLOC_REQ, FREE_VALID, FREE_PREG, WB_VALID, WB_PREG,
        input  ALLOC_PREG, ALLOC_GNT, STALL, FREE_COUNT, READY_BITS, ERR_DOUBLE_FREE
    );

    modport slave (
        input  ALLOC_REQ, FREE_VALID, FREE_PREG, WB_VALID, WB_PREG,
        output ALLOC_PREG, ALLOC_GNT, STALL, FREE_COUNT, READY_BITS, ERR_DOUBLE_FREE
    );

endinterface

// File: rtl/preg_free_list.sv
// Physical register free list: 32-entry circular FIFO plus per-register ready bits.
// Define FREELIST_DOUBLE_FREE_CHECK_EN to track allocation and reject/flag bad frees.
module preg_free_list
    import preg_free_list_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    preg_free_list_if.slave  fl
);

    preg_t               fifo_q [FL_DEPTH];
    fl_ptr_t             head_q;
    fl_ptr_t             tail_q;
    fl_cnt_t             count_q;
    logic [NUM_PREG-1:0] ready_q;
    logic [NUM_PREG-1:0] ready_n;

    logic empty;
    logic full;
    logic gnt;
    logic free_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == fl_cnt_t'(FL_DEPTH));
    assign gnt     = fl.ALLOC_REQ && !empty;

    assign fl.ALLOC_PREG = fifo_q[head_q];
    assign fl.ALLOC_GNT  = gnt;
    assign fl.STALL      = empty;
    assign fl.FREE_COUNT = count_q;
    assign fl.READY_BITS = ready_q;

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    logic [NUM_PREG-1:0] alloc_q;
    logic [NUM_PREG-1:0] alloc_n;
    logic                err_q;

    assign free_ok = fl.FREE_VALID && !full && alloc_q[fl.FREE_PREG];
    assign fl.ERR_DOUBLE_FREE = err_q;

    // A granted register is never also a legal free in the same cycle, so order is moot.
    always_comb begin
        alloc_n = alloc_q;
        if (free_ok) alloc_n[fl.FREE_PREG] = 1'b0;
        if (gnt)     alloc_n[fifo_q[head_q]] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_PREG; i++) alloc_q[i] <= (i < NUM_AREG);
            err_q <= 1'b0;
        end else begin
            alloc_q <= alloc_n;
            err_q   <= fl.FREE_VALID && !free_ok;
        end
    end
`else
    assign free_ok = fl.FREE_VALID && !full;
    assign fl.ERR_DOUBLE_FREE = 1'b0;
`endif

    // Allocation clear is applied last so it wins over a same-cycle writeback.
    always_comb begin
        ready_n = ready_q;
        if (fl.WB_VALID) ready_n[fl.WB_PREG]    = 1'b1;
        if (gnt)         ready_n[fifo_q[head_q]] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < FL_DEPTH; i++) fifo_q[i] <= preg_t'(NUM_AREG + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= fl_cnt_t'(FL_DEPTH);
            ready_q <= '1;
        end else begin
            ready_q <= ready_n;
            if (gnt) head_q <= ptr_inc(head_q);
            if (free_ok) begin
                fifo_q[tail_q] <= fl.FREE_PREG;
                tail_q         <= ptr_inc(tail_q);
            end
            if (gnt && !free_ok)      count_q <= count_q - fl_cnt_t'(1);
            else if (!gnt && free_ok) count_q <= count_q + fl_cnt_t'(1);
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Randomized scoreboard bench for preg_free_list against a queue-based free-list model.
// Expectations follow FREELIST_DOUBLE_FREE_CHECK_EN when it is defined for the build.
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  localparam int W = 80;  // {preg_chk, err, gnt, stall, preg[6], count[6], ready[64]}

  logic CLK;
  logic RESET;
  preg_free_list_if fl_if ();

  preg_free_list dut (
    .CLK   (CLK),
    .RESET (RESET),
    .fl    (fl_if)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model: the free list is literally a queue of register numbers
  int   m_fl[$];
  bit   m_ready [NUM_PREG];
  bit   m_alloc [NUM_PREG];
  bit   m_err;

  function automatic void model_reset();
    m_fl.delete();
    for (int i = 0; i < FL_DEPTH; i++) m_fl.push_back(NUM_AREG + i);
    for (int i = 0; i < NUM_PREG; i++) begin
      m_ready[i] = 1'b1;
      m_alloc[i] = (i < NUM_AREG);
    end
    m_err = 1'b0;
  endfunction

  function automatic int pick_alloc();
    int s;
    s = $urandom_range(0, NUM_PREG - 1);
    for (int k = 0; k < NUM_PREG; k++)
      if (m_alloc[(s + k) % NUM_PREG]) return (s + k) % NUM_PREG;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // driver: one cycle of stimulus, expected outputs pushed, then the model advances
  task automatic step(input logic areq, input logic fv, input int fp, input logic wv, input int wp);
    int           cnt;
    logic         e_gnt;
    logic [5:0]   e_preg;
    logic [63:0]  e_ready;
    bit           ok;
    int           g;
    @(negedge CLK);
    #1;
    fl_if.ALLOC_REQ  = areq;
    fl_if.FREE_VALID = fv;
    fl_if.FREE_PREG  = 6'(fp);
    fl_if.WB_VALID   = wv;
    fl_if.WB_PREG    = 6'(wp);
    cnt    = m_fl.size();
    e_gnt  = areq && (cnt != 0);
    e_preg = (cnt != 0) ? 6'(m_fl[0]) : 6'd0;
    for (int i = 0; i < NUM_PREG; i++) e_ready[i] = m_ready[i];
    exp_q.push_back({(cnt != 0), m_err, e_gnt, (cnt == 0), e_preg, 6'(cnt), e_ready});
`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    ok    = fv && (cnt < FL_DEPTH) && m_alloc[fp];
    m_err = fv && !ok;
`else
    ok    = fv && (cnt < FL_DEPTH);
    m_err = 1'b0;
`endif
    if (wv) m_ready[wp] = 1'b1;
    if (e_gnt) begin
      g = m_fl.pop_front();
      m_alloc[g] = 1'b1;
      m_ready[g] = 1'b0;
    end
    if (ok) begin
      m_fl.push_back(fp);
      m_alloc[fp] = 1'b0;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  // reset asserted mid-cycle while a grant and a free are being presented
  task automatic do_reset();
    @(negedge CLK);
    #1;
    fl_if.ALLOC_REQ  = 1'b1;
    fl_if.FREE_VALID = 1'b1;
    fl_if.FREE_PREG  = 6'd3;
    #2 RESET = 1'b0;
    @(posedge CLK);
    #2;
    fl_if.ALLOC_REQ  = 1'b0;
    fl_if.FREE_VALID = 1'b0;
    RESET = 1'b1;
    model_reset();
  endtask

  // monitor: compares whatever the driver queued for this cycle
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("alloc_gnt", 64'(fl_if.ALLOC_GNT), 64'(e[77]));
        check("stall", 64'(fl_if.STALL), 64'(e[76]));
        check("free_count", 64'(fl_if.FREE_COUNT), 64'(e[69:64]));
        check("ready_bits", fl_if.READY_BITS, e[63:0]);
        check("err_double_free", 64'(fl_if.ERR_DOUBLE_FREE), 64'(e[78]));
        if (e[79]) check("alloc_preg", 64'(fl_if.ALLOC_PREG), 64'(e[75:70]));
      end
    end
  end

  initial begin
    fl_if.ALLOC_REQ  = 1'b0;
    fl_if.FREE_VALID = 1'b0;
    fl_if.FREE_PREG  = '0;
    fl_if.WB_VALID   = 1'b0;
    fl_if.WB_PREG    = '0;
    RESET = 1'b0;
    model_reset();
    #12 RESET = 1'b1;

    // first grant is P32, then P33 granted while written back, then written back again
    idle();
    step(1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 1'b1, 33);
    step(1'b0, 1'b0, 0, 1'b1, 33);
    idle();

    // drain the rest back-to-back, then hold the request while empty
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 0, 1'b0, 0);

    // free into an empty list with a request pending: no bypass, granted next cycle
    step(1'b1, 1'b1, 40, 1'b0, 0);
    step(1'b1, 1'b0, 0, 1'b0, 0);
    idle();

    // refill to 5, then grant and free together long enough to wrap the tail
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, pick_alloc(), 1'b0, 0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, pick_alloc(), 1'b0, 0);
    idle();

    // bad frees: P50 at full after reset, then P50 again at count 31 while still free
    do_reset();
    step(1'b0, 1'b1, 50, 1'b0, 0);
    step(1'b1, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b1, 50, 1'b0, 0);
    idle();
    idle();

    // random traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 8) ? pick_alloc() : int'($urandom_range(0, NUM_PREG - 1)),
           1'($urandom_range(0, 3) == 0),
           int'($urandom_range(0, NUM_PREG - 1)));
    end
    idle();
    @(negedge CLK);
    @(negedge CLK);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 SHALL have ports: CLK input 1, rising-edge clock; RESET input 1, asynchronous active-low reset.
REQ-002 SHALL have ports: ALLOC_REQ input 1, rename requests one physical register this cycle; ALLOC_PREG output 6, register granted (head of list); ALLOC_GNT output 1, allocation taken this cycle.
REQ-003 SHALL have ports: STALL output 1, no free register available; FREE_COUNT output 6, number of free registers (0..32).
REQ-004 SHALL have ports: FREE_VALID input 1, commit returns a register; FREE_PREG input 6, register returned.
REQ-005 SHALL have ports: WB_VALID input 1, writeback produced a value; WB_PREG input 6, register written; READY_BITS output 64, bit n = 1 when P(n) holds a valid value.
REQ-006 SHALL have port ERR_DOUBLE_FREE output 1, one-cycle pulse on a rejected free.

Function
REQ-007 SHALL hold free registers in a 32-entry circular FIFO with 5-bit head/tail pointers and a 6-bit count.
REQ-008 SHALL drive ALLOC_PREG combinationally from the head entry; value is don't-care when count = 0.
REQ-009 SHALL assert STALL combinationally when count = 0, deasserted otherwise.
REQ-010 SHALL assert ALLOC_GNT = ALLOC_REQ && count != 0; on grant, advance head by 1 (wrapping 31 -> 0) at the clock edge.
REQ-011 SHALL, on FREE_VALID with free accepted, write FREE_PREG at tail and advance tail by 1 (wrapping 31 -> 0).
REQ-012 SHALL NOT bypass: a free in a cycle with count = 0 is not grantable that same cycle; STALL stays 1 that cycle.
REQ-013 SHALL handle simultaneous grant and accepted free: both pointers advance, count unchanged.
REQ-014 SHALL reject a free when count = 32 (full); count and pointers unchanged.
REQ-015 SHALL clear READY_BITS[ALLOC_PREG] at the edge of a grant.
REQ-016 SHALL set READY_BITS[WB_PREG] at the edge when WB_VALID = 1.
REQ-017 SHALL let the allocation clear win when a grant and a WB_VALID target the same register in one cycle.
REQ-018 SHALL leave READY_BITS unchanged on frees.
REQ-019 SHALL drive FREE_COUNT from the registered count; it reflects an edge's grant or free one cycle later.

Reset
REQ-020 SHALL, on RESET low, asynchronously load FIFO entries 0..31 with P32..P63, head = 0, tail = 0, count = 32.
REQ-021 SHALL, on RESET low, set READY_BITS to all ones and the allocated bitmap (if present) to ones for P0..P31 and zeros for P32..P63.
REQ-022 SHALL, on RESET low, drive ERR_DOUBLE_FREE to 0.
REQ-023 SHALL discard an in-flight grant or free when reset asserts mid-cycle; state after release equals REQ-020/021.

Configuration
REQ-024 SHALL, when FREELIST_DOUBLE_FREE_CHECK_EN is defined, keep a 64-bit allocated bitmap: set on free-list exit (grant), clear on accepted free.
REQ-025 SHALL, with the macro defined, reject a free whose register is not allocated (as well as on full), and pulse ERR_DOUBLE_FREE for 1 cycle on either rejection.
REQ-026 SHALL, without the macro, have no bitmap, tie ERR_DOUBLE_FREE to 0, and reject frees only on full.

Structure
REQ-027 SHALL take NUM_PREG = 64, NUM_AREG = 32, PREG_W = 6 and FL_DEPTH = 32 from the shared core package, the package shared with the issue queue and rename.
REQ-028 SHALL be a single module; no sub-module is required.

Verification
REQ-029 SHALL verify reset then ALLOC_REQ for 1 cycle -> ALLOC_PREG = 32, ALLOC_GNT = 1, next cycle FREE_COUNT = 31 and READY_BITS[32] = 0.
REQ-030 SHALL verify 32 back-to-back grants -> registers 32..63 in order, then STALL = 1, ALLOC_GNT = 0 with ALLOC_REQ held, FREE_COUNT = 0.
REQ-031 SHALL verify, from empty, FREE_VALID with P40 while ALLOC_REQ = 1 -> no grant that cycle; next cycle ALLOC_PREG = 40 and the grant is taken.
REQ-032 SHALL verify simultaneous grant and free at count = 5 -> count stays 5; tail wrap 31 -> 0 preserves order across the wrap.
REQ-033 SHALL verify, with the macro defined, a free of P50 while P50 is already free -> ERR_DOUBLE_FREE pulses 1 cycle and count is unchanged; without the macro, a free at count = 32 -> dropped.
REQ-034 SHALL verify a grant of P33 with WB_VALID on P33 in the same cycle -> READY_BITS[33] = 0; a later WB_VALID on P33 -> READY_BITS[33] = 1.
